// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin owner selection and start/busy sequencing for one shared
// signed Booth multiplier. Define BOOTH_ARB_WATCHDOG_EN to add the ISSUE/WAIT timeout abort.
//
// state | meaning
// IDLE  | no owner; issues to the round-robin winner once the multiplier is idle
// ISSUE | owner granted, operands latched, mul_start held until busy is seen
// WAIT  | multiplier running; product captured when busy drops
// DONE  | done pulse to owner, pointer moves past owner, grant released

module booth_mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [2*WIDTH-1:0]    product,
  output logic                  mul_start,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [2*WIDTH-1:0]    mul_ab,
  input  logic                  mul_busy,
  output logic                  err
);

  localparam int              PTR_W  = $clog2(NREQ);
  localparam logic [PTR_W:0]  NREQ_X = (PTR_W + 1)'(NREQ);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] owner_inc;
  logic [NREQ-1:0]  owner_oh;

  logic [NREQ-1:0]  req_rot;
  logic             win_found;
  logic [PTR_W-1:0] win_off;
  logic [PTR_W:0]   win_sum;
  logic [PTR_W-1:0] win_idx;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  logic             issue_go;
  logic             finish_go;
  logic             abort_go;

  // Rotate so that bit 0 is the requester currently holding top priority.
  assign req_rot = NREQ'({req, req} >> ptr);

  always_comb begin
    win_found = 1'b0;
    win_off   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req_rot[i]) begin
        win_found = 1'b1;
        win_off   = PTR_W'(i);
      end
    end
  end

  assign win_sum = {1'b0, ptr} + {1'b0, win_off};
  assign win_idx = (win_sum >= NREQ_X) ? PTR_W'(win_sum - NREQ_X) : PTR_W'(win_sum);

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        sel_a = a_in[i*WIDTH +: WIDTH];
        sel_b = b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign owner_oh  = NREQ'(1) << owner;
  assign owner_inc = (owner == LAST) ? '0 : owner + PTR_W'(1);

  // The multiplier may still be finishing a job that a reset cut short.
  assign issue_go  = (state == S_IDLE) && win_found && !mul_busy;
  assign finish_go = (state == S_WAIT) && !mul_busy;

`ifdef BOOTH_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_run;
  logic            err_q;

  assign wd_run = (state == S_ISSUE) || (state == S_WAIT);
  // A normal completion in the same cycle as the terminal count wins.
  assign abort_go = wd_run && (wd_cnt == '0) && !finish_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= abort_go;
      if (issue_go) begin
        wd_cnt <= WD_W'(TIMEOUT - 1);
      end else if (wd_run && (wd_cnt != '0)) begin
        wd_cnt <= wd_cnt - 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign abort_go = 1'b0;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (issue_go) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (abort_go) state_nxt = S_IDLE;
        else if (mul_busy) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (finish_go) state_nxt = S_DONE;
        else if (abort_go) state_nxt = S_IDLE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mul_start = (state == S_ISSUE);
    grant     = '0;
    if (state != S_IDLE) grant = owner_oh;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '0;
      owner   <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      product <= '0;
      done    <= '0;
    end else begin
      done <= '0;
      if (issue_go) begin
        owner <= win_idx;
        mul_a <= sel_a;
        mul_b <= sel_b;
      end
      if (finish_go) begin
        product <= mul_ab;
        done    <= owner_oh;
      end
      if (abort_go) begin
        product <= '0;
        done    <= owner_oh;
      end
      if ((state == S_DONE) || abort_go) ptr <= owner_inc;
    end
  end

endmodule
